ysyx_22050854_axi_rd_responder: RTL and testbench
=================================================

YSYX_22050854_AXI_RD_RESPONDER -- requirements
Module: ysyx_22050854_axi_rd_responder

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1, meaning cycles from mem_ren to valid mem_rdata (legal 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all flops on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 SHALL have AR ports: arvalid in 1, arready out 1, arid in 4 (0001 = IFU, 0010 = LSU), araddr in 32, arlen in 8, arsize in 3, arburst in 2.
REQ-005 SHALL have R ports: rvalid out 1, rready in 1, rid out 4, rdata out 64, rresp out 2, rlast out 1.
REQ-006 SHALL have memory ports: mem_ren out 1 (read strobe), mem_raddr out 32, mem_rdata in 64.

Function
REQ-007 SHALL implement FSM IDLE -> WAIT -> DATA; DATA -> WAIT on a non-last beat handshake; DATA -> IDLE on the last beat handshake.
REQ-008 SHALL drive arready=1 only in IDLE; on arvalid&&arready, it SHALL latch arid, araddr, arlen, arsize and arburst, then enter WAIT.
REQ-009 SHALL assert mem_ren for exactly one cycle on each WAIT entry, with mem_raddr equal to the current beat address.
REQ-010 SHALL load the latency counter with RD_LATENCY at WAIT entry and decrement it each cycle; at 0 it SHALL capture mem_rdata into rdata and enter DATA.
REQ-011 SHALL drive rvalid=1 only in DATA; rdata, rid, rresp and rlast SHALL stay stable while rvalid&&!rready.
REQ-012 SHALL assert rlast when the beat count equals the latched arlen; arlen=0 SHALL mean a single beat.
REQ-013 SHALL compute the beat address for INCR (01) as the previous address + (1<<arsize), 32-bit wrap-around with no 4KB check.
REQ-014 SHALL hold the beat address constant for FIXED (00).
REQ-015 SHALL treat WRAP (10) and reserved (11) bursts as errors: rresp=SLVERR (10) and rdata=0 on every beat, with arlen+1 beats still returned, no mem_ren issued and no WAIT delay (IDLE -> DATA directly).
REQ-016 SHALL return rresp=OKAY (00) in all other cases.
REQ-017 SHALL drive rid equal to the latched arid on every beat.
REQ-018 SHALL deassert arready for at least one cycle after the last handshake; an AR accepted on the same edge as the last handshake is impossible by construction.
REQ-019 SHALL ignore arvalid outside IDLE; an ignored address is not queued.

Reset
REQ-020 SHALL, on rst=0 at any time including mid-burst, force the FSM to IDLE and abandon the outstanding burst.
REQ-021 SHALL, during reset, hold rvalid, rlast, mem_ren and arready at 0 and rdata, rid, rresp, mem_raddr and the counters at 0.
REQ-022 SHALL assert arready=1 on the first clock edge after rst rises.

Configuration
REQ-023 SHALL support macro YSYX_22050854_RD_ALIGN_CHK_EN.
REQ-024 SHALL, when YSYX_22050854_RD_ALIGN_CHK_EN is defined, treat a request with araddr & ((1<<arsize)-1) != 0, or with arsize > 3, exactly as an error burst per REQ-015.
REQ-025 SHALL, when YSYX_22050854_RD_ALIGN_CHK_EN is undefined, pass araddr to memory unchecked, with arsize > 3 clamped to 3 for increments.

Structure
REQ-026 SHALL take burst encodings, resp encodings, the FSM state enum, and the ID constants (IFU=0001, LSU=0010) from shared package ysyx_22050854_axi_pkg.
REQ-027 SHALL implement next-beat address generation in sub-module ysyx_22050854_axi_addr_gen, which is combinational and takes addr, size and burst.

Verification
REQ-028 SHALL cover: RD_LATENCY=1; AR id=0001, addr=0x80000000, len=0, INCR; rready=1 -> mem_ren at 0x80000000; one R beat 2 cycles after accept with rid=0001, rlast=1, rresp=00.
REQ-029 SHALL cover: AR len=3, size=3, INCR, addr=0x80000010 -> mem_raddr 0x80000010, 0x18, 0x20, 0x28; 4 beats; rlast on beat 4 only.
REQ-030 SHALL cover: rready held 0 for 5 cycles in DATA -> rvalid stays 1 and rdata, rid, rlast stay unchanged; the beat completes on the first rready=1 cycle.
REQ-031 SHALL cover: AR burst=10, len=1 -> 2 beats with rresp=10 and rdata=0; mem_ren never asserted.
REQ-032 SHALL cover: with the macro defined, addr=0x80000004, size=3 -> SLVERR beat; without the macro -> OKAY with mem_raddr=0x80000004.
REQ-033 SHALL cover: rst pulsed low during beat 2 of a len=3 burst -> rvalid=0 immediately, arready=1 one edge after release, and the next AR is served normally.

Source files
------------

// File: rtl/ysyx_22050854_axi_rd_responder_pkg.sv
// rtl/ysyx_22050854_axi_rd_responder_pkg.sv - shared AXI read encodings, FSM states and ID constants
package ysyx_22050854_axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [3:0] ID_IFU = 4'b0001;
  localparam logic [3:0] ID_LSU = 4'b0010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DATA = 2'd2
  } state_t;

  function automatic logic addr_misaligned(input logic [31:0] addr, input logic [2:0] size);
    return (size > 3'd3) || ((addr & ((32'd1 << size) - 32'd1)) != 32'd0);
  endfunction

endpackage

// File: rtl/ysyx_22050854_axi_rd_responder_if.sv
// rtl/ysyx_22050854_axi_rd_responder_if.sv - AXI read address / read data channel bundle
interface ysyx_22050854_axi_rd_responder_if;
  logic        arvalid;
  logic        arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/ysyx_22050854_axi_rd_responder_addr_gen.sv
// rtl/ysyx_22050854_axi_rd_responder_addr_gen.sv - combinational next-beat address for FIXED/INCR bursts
module ysyx_22050854_axi_addr_gen
  import ysyx_22050854_axi_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);

  logic [2:0] eff_size;

  always_comb begin
    next_addr = addr;
    // Beats wider than the 64-bit data bus step by 8 bytes
    eff_size  = (size > 3'd3) ? 3'd3 : size;
    if (burst == BURST_INCR) begin
      next_addr = addr + (32'd1 << eff_size);
    end
  end

endmodule

// File: rtl/ysyx_22050854_axi_rd_responder.sv
// rtl/ysyx_22050854_axi_rd_responder.sv - AXI read responder fronting a fixed-latency memory
// Optional alignment check enabled by macro YSYX_22050854_RD_ALIGN_CHK_EN.
module ysyx_22050854_axi_rd_responder
  import ysyx_22050854_axi_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  ysyx_22050854_axi_rd_responder_if.slave bus,
  output logic                            mem_ren,
  output logic [31:0]                     mem_raddr,
  input  logic [63:0]                     mem_rdata
);

  state_t      state;
  logic        arready_q;
  logic        rvalid_q;
  logic        rlast_q;
  logic [1:0]  rresp_q;
  logic [63:0] rdata_q;
  logic [3:0]  id_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic        err_q;
  logic [7:0]  beat_cnt;
  logic [3:0]  lat_cnt;
  logic        ar_err;
  logic [31:0] next_addr;

  always_comb begin
    ar_err = (bus.arburst == BURST_WRAP) || (bus.arburst == BURST_RSVD);
`ifdef YSYX_22050854_RD_ALIGN_CHK_EN
    ar_err = ar_err || addr_misaligned(bus.araddr, bus.arsize);
`endif
  end

  ysyx_22050854_axi_addr_gen u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rlast   = rlast_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;
  assign bus.rid     = id_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= 64'd0;
      id_q      <= 4'd0;
      addr_q    <= 32'd0;
      len_q     <= 8'd0;
      size_q    <= 3'd0;
      burst_q   <= 2'b00;
      err_q     <= 1'b0;
      beat_cnt  <= 8'd0;
      lat_cnt   <= 4'd0;
      mem_ren   <= 1'b0;
      mem_raddr <= 32'd0;
    end else begin
      mem_ren <= 1'b0;
      case (state)
        S_IDLE: begin
          // Re-arms one cycle after entering IDLE, leaving a gap after the last beat
          arready_q <= 1'b1;
          if (bus.arvalid && arready_q) begin
            arready_q <= 1'b0;
            id_q      <= bus.arid;
            addr_q    <= bus.araddr;
            len_q     <= bus.arlen;
            size_q    <= bus.arsize;
            burst_q   <= bus.arburst;
            err_q     <= ar_err;
            beat_cnt  <= 8'd0;
            if (ar_err) begin
              state    <= S_DATA;
              rvalid_q <= 1'b1;
              rdata_q  <= 64'd0;
              rresp_q  <= RESP_SLVERR;
              rlast_q  <= (bus.arlen == 8'd0);
            end else begin
              state     <= S_WAIT;
              mem_ren   <= 1'b1;
              mem_raddr <= bus.araddr;
              lat_cnt   <= 4'(RD_LATENCY);
            end
          end
        end
        S_WAIT: begin
          if (lat_cnt == 4'd0) begin
            state    <= S_DATA;
            rvalid_q <= 1'b1;
            rdata_q  <= mem_rdata;
            rresp_q  <= RESP_OKAY;
            rlast_q  <= (beat_cnt == len_q);
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        S_DATA: begin
          if (bus.rready) begin
            if (rlast_q) begin
              state    <= S_IDLE;
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
              addr_q   <= next_addr;
              if (err_q) begin
                // Error beats stream back to back with rdata/rresp unchanged
                rlast_q <= ((beat_cnt + 8'd1) == len_q);
              end else begin
                state     <= S_WAIT;
                rvalid_q  <= 1'b0;
                mem_ren   <= 1'b1;
                mem_raddr <= next_addr;
                lat_cnt   <= 4'(RD_LATENCY);
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050854_axi_rd_responder.sv
// tb/tb_ysyx_22050854_axi_rd_responder.sv - directed bench for the AXI read responder
module tb_ysyx_22050854_axi_rd_responder;
  import ysyx_22050854_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_ren;
  logic [31:0] mem_raddr;
  logic [63:0] mem_rdata = 64'd0;

  int checks = 0;
  int passes = 0;

  logic [31:0] mem_log[$];
  logic [63:0] b_data[$];
  logic [1:0]  b_resp[$];
  logic        b_last[$];
  logic [3:0]  b_id[$];

  ysyx_22050854_axi_rd_responder_if bus();

  ysyx_22050854_axi_rd_responder #(.RD_LATENCY(1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, a};
  endfunction

  // One-cycle-latency memory: data for a strobe is ready before the following edge
  always @(negedge clk) begin
    if (mem_ren) begin
      mem_log.push_back(mem_raddr);
      mem_rdata = mem_word(mem_raddr);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit took = 1'b0;
    bus.arvalid = 1'b1; bus.arid = id; bus.araddr = addr;
    bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    for (int i = 0; i < 20 && !took; i++) begin
      took = bus.arready;
      tick();
    end
    bus.arvalid = 1'b0;
    checks++; if (!took) $display("FAIL ar_accept: arready got 0 want 1 within 20 cycles"); else passes++;
  endtask

  task automatic collect(input int max_cycles);
    bit done = 1'b0;
    b_data.delete(); b_resp.delete(); b_last.delete(); b_id.delete();
    bus.rready = 1'b1;
    for (int i = 0; i < max_cycles && !done; i++) begin
      if (bus.rvalid) begin
        b_data.push_back(bus.rdata); b_resp.push_back(bus.rresp);
        b_last.push_back(bus.rlast); b_id.push_back(bus.rid);
        done = bus.rlast;
      end
      tick();
    end
    checks++; if (!done) $display("FAIL collect_timeout: rlast got 0 want 1 within %0d cycles", max_cycles); else passes++;
  endtask

  task automatic test_reset;
    repeat (3) tick();
    checks++; if (bus.arready !== 1'b0) $display("FAIL rst_arready: got %b want 0", bus.arready); else passes++;
    checks++; if (bus.rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b want 0", bus.rvalid); else passes++;
    checks++; if (bus.rlast !== 1'b0) $display("FAIL rst_rlast: got %b want 0", bus.rlast); else passes++;
    checks++; if (mem_ren !== 1'b0) $display("FAIL rst_mem_ren: got %b want 0", mem_ren); else passes++;
    checks++; if (bus.rdata !== 64'd0) $display("FAIL rst_rdata: got %h want 0", bus.rdata); else passes++;
    checks++; if (bus.rid !== 4'd0) $display("FAIL rst_rid: got %h want 0", bus.rid); else passes++;
    checks++; if (bus.rresp !== 2'd0) $display("FAIL rst_rresp: got %h want 0", bus.rresp); else passes++;
    checks++; if (mem_raddr !== 32'd0) $display("FAIL rst_mem_raddr: got %h want 0", mem_raddr); else passes++;
    rst = 1'b1;
    tick();
    checks++; if (bus.arready !== 1'b1) $display("FAIL rst_release_arready: got %b want 1", bus.arready); else passes++;
  endtask

  task automatic test_single_beat;
    mem_log.delete();
    bus.rready = 1'b1;
    send_ar(ID_IFU, 32'h8000_0000, 8'd0, 3'd3, BURST_INCR);
    checks++; if (mem_ren !== 1'b1) $display("FAIL single_mem_ren: got %b want 1", mem_ren); else passes++;
    checks++; if (mem_raddr !== 32'h8000_0000) $display("FAIL single_mem_raddr: got %h want 80000000", mem_raddr); else passes++;
    checks++; if (bus.rvalid !== 1'b0) $display("FAIL single_rvalid_c0: got %b want 0", bus.rvalid); else passes++;
    tick();
    checks++; if (bus.rvalid !== 1'b0) $display("FAIL single_rvalid_c1: got %b want 0", bus.rvalid); else passes++;
    checks++; if (mem_ren !== 1'b0) $display("FAIL single_mem_ren_c1: got %b want 0", mem_ren); else passes++;
    tick();
    checks++; if (bus.rvalid !== 1'b1) $display("FAIL single_rvalid_c2: got %b want 1", bus.rvalid); else passes++;
    checks++; if (bus.rid !== ID_IFU) $display("FAIL single_rid: got %h want 1", bus.rid); else passes++;
    checks++; if (bus.rlast !== 1'b1) $display("FAIL single_rlast: got %b want 1", bus.rlast); else passes++;
    checks++; if (bus.rresp !== RESP_OKAY) $display("FAIL single_rresp: got %h want 0", bus.rresp); else passes++;
    checks++; if (bus.rdata !== mem_word(32'h8000_0000)) $display("FAIL single_rdata: got %h want %h", bus.rdata, mem_word(32'h8000_0000)); else passes++;
    tick();
    checks++; if (bus.rvalid !== 1'b0) $display("FAIL single_rvalid_done: got %b want 0", bus.rvalid); else passes++;
    checks++; if (bus.arready !== 1'b0) $display("FAIL single_arready_gap: got %b want 0", bus.arready); else passes++;
    tick();
    checks++; if (bus.arready !== 1'b1) $display("FAIL single_arready_rearm: got %b want 1", bus.arready); else passes++;
    checks++; if (mem_log.size() !== 1) $display("FAIL single_mem_reads: got %0d want 1", mem_log.size()); else passes++;
  endtask

  task automatic test_incr_burst;
    logic [31:0] exp_addr;
    mem_log.delete();
    send_ar(ID_LSU, 32'h8000_0010, 8'd3, 3'd3, BURST_INCR);
    collect(100);
    checks++; if (b_data.size() !== 4) $display("FAIL incr_beats: got %0d want 4", b_data.size()); else passes++;
    checks++; if (mem_log.size() !== 4) $display("FAIL incr_mem_reads: got %0d want 4", mem_log.size()); else passes++;
    for (int i = 0; i < 4; i++) begin
      exp_addr = 32'h8000_0010 + 32'(i * 8);
      checks++; if (mem_log[i] !== exp_addr) $display("FAIL incr_mem_raddr[%0d]: got %h want %h", i, mem_log[i], exp_addr); else passes++;
      checks++; if (b_data[i] !== mem_word(exp_addr)) $display("FAIL incr_rdata[%0d]: got %h want %h", i, b_data[i], mem_word(exp_addr)); else passes++;
      checks++; if (b_last[i] !== (i == 3)) $display("FAIL incr_rlast[%0d]: got %b want %b", i, b_last[i], (i == 3)); else passes++;
      checks++; if (b_id[i] !== ID_LSU || b_resp[i] !== RESP_OKAY) $display("FAIL incr_id_resp[%0d]: got %h/%h want 2/0", i, b_id[i], b_resp[i]); else passes++;
    end
  endtask

  task automatic test_fixed_burst;
    mem_log.delete();
    send_ar(ID_LSU, 32'h8000_0400, 8'd1, 3'd3, BURST_FIXED);
    collect(100);
    checks++; if (mem_log.size() !== 2) $display("FAIL fixed_mem_reads: got %0d want 2", mem_log.size()); else passes++;
    checks++; if (mem_log[1] !== 32'h8000_0400) $display("FAIL fixed_addr: got %h want 80000400", mem_log[1]); else passes++;
    checks++; if (b_data[1] !== mem_word(32'h8000_0400)) $display("FAIL fixed_rdata: got %h want %h", b_data[1], mem_word(32'h8000_0400)); else passes++;
  endtask

  task automatic test_backpressure;
    bus.rready = 1'b0;
    send_ar(ID_IFU, 32'h8000_0100, 8'd0, 3'd2, BURST_INCR);
    for (int i = 0; i < 20 && !bus.rvalid; i++) tick();
    checks++; if (bus.rvalid !== 1'b1) $display("FAIL bp_rvalid_rise: got %b want 1", bus.rvalid); else passes++;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.rvalid !== 1'b1) $display("FAIL bp_rvalid_hold[%0d]: got %b want 1", i, bus.rvalid); else passes++;
      checks++; if (bus.rdata !== mem_word(32'h8000_0100) || bus.rid !== ID_IFU || bus.rlast !== 1'b1)
        $display("FAIL bp_stable[%0d]: got %h/%h/%b want %h/1/1", i, bus.rdata, bus.rid, bus.rlast, mem_word(32'h8000_0100)); else passes++;
    end
    bus.rready = 1'b1;
    tick();
    checks++; if (bus.rvalid !== 1'b0) $display("FAIL bp_complete: got %b want 0", bus.rvalid); else passes++;
  endtask

  task automatic test_error_burst;
    mem_log.delete();
    bus.rready = 1'b1;
    send_ar(ID_LSU, 32'h8000_0200, 8'd1, 3'd3, BURST_WRAP);
    checks++; if (bus.rvalid !== 1'b1) $display("FAIL err_no_wait: got %b want 1", bus.rvalid); else passes++;
    collect(50);
    checks++; if (b_data.size() !== 2) $display("FAIL err_beats: got %0d want 2", b_data.size()); else passes++;
    for (int i = 0; i < 2; i++) begin
      checks++; if (b_resp[i] !== RESP_SLVERR || b_data[i] !== 64'd0) $display("FAIL err_beat[%0d]: got %h/%h want 2/0", i, b_resp[i], b_data[i]); else passes++;
      checks++; if (b_last[i] !== (i == 1)) $display("FAIL err_rlast[%0d]: got %b want %b", i, b_last[i], (i == 1)); else passes++;
    end
    send_ar(ID_IFU, 32'h8000_0200, 8'd0, 3'd3, 2'b11);
    collect(50);
    checks++; if (b_resp[0] !== RESP_SLVERR || b_last[0] !== 1'b1) $display("FAIL rsvd_beat: got %h/%b want 2/1", b_resp[0], b_last[0]); else passes++;
    checks++; if (mem_log.size() !== 0) $display("FAIL err_mem_reads: got %0d want 0", mem_log.size()); else passes++;
  endtask

  task automatic test_align;
    mem_log.delete();
    send_ar(ID_LSU, 32'h8000_0004, 8'd0, 3'd3, BURST_INCR);
    collect(50);
`ifdef YSYX_22050854_RD_ALIGN_CHK_EN
    checks++; if (b_resp[0] !== RESP_SLVERR || b_data[0] !== 64'd0) $display("FAIL align_err: got %h/%h want 2/0", b_resp[0], b_data[0]); else passes++;
    checks++; if (mem_log.size() !== 0) $display("FAIL align_mem_reads: got %0d want 0", mem_log.size()); else passes++;
`else
    checks++; if (b_resp[0] !== RESP_OKAY || b_data[0] !== mem_word(32'h8000_0004)) $display("FAIL align_ok: got %h/%h want 0/%h", b_resp[0], b_data[0], mem_word(32'h8000_0004)); else passes++;
    checks++; if (mem_log[0] !== 32'h8000_0004) $display("FAIL align_mem_raddr: got %h want 80000004", mem_log[0]); else passes++;
`endif
  endtask

  task automatic test_reset_midburst;
    int nb = 0;
    bit at_beat2 = 1'b0;
    bus.rready = 1'b1;
    send_ar(ID_LSU, 32'h8000_0500, 8'd3, 3'd3, BURST_INCR);
    for (int i = 0; i < 50 && !at_beat2; i++) begin
      if (bus.rvalid) begin
        nb++;
        at_beat2 = (nb == 2);
      end
      if (!at_beat2) tick();
    end
    checks++; if (!at_beat2) $display("FAIL mid_beat2: got %0d beats want 2", nb); else passes++;
    rst = 1'b0;
    #1;
    checks++; if (bus.rvalid !== 1'b0) $display("FAIL mid_rvalid: got %b want 0", bus.rvalid); else passes++;
    checks++; if (bus.arready !== 1'b0 || mem_ren !== 1'b0) $display("FAIL mid_arready_ren: got %b/%b want 0/0", bus.arready, mem_ren); else passes++;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++; if (bus.arready !== 1'b1) $display("FAIL mid_arready_release: got %b want 1", bus.arready); else passes++;
    send_ar(ID_IFU, 32'h8000_0600, 8'd0, 3'd3, BURST_INCR);
    collect(50);
    checks++; if (b_data.size() !== 1 || b_resp[0] !== RESP_OKAY || b_id[0] !== ID_IFU) $display("FAIL mid_next_ar: got %0d/%h/%h want 1/0/1", b_data.size(), b_resp[0], b_id[0]); else passes++;
    checks++; if (b_data[0] !== mem_word(32'h8000_0600)) $display("FAIL mid_next_rdata: got %h want %h", b_data[0], mem_word(32'h8000_0600)); else passes++;
  endtask

  initial begin
    bus.arvalid = 1'b0; bus.arid = 4'd0; bus.araddr = 32'd0; bus.arlen = 8'd0;
    bus.arsize = 3'd0; bus.arburst = 2'b00; bus.rready = 1'b0;
    test_reset();
    test_single_beat();
    test_incr_burst();
    test_fixed_burst();
    test_backpressure();
    test_error_burst();
    test_align();
    test_reset_midburst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
